// File: rtl/link_watchdog.sv
// link_watchdog: receive-activity watchdog that pulses a reset request to the reset sequencer.
// Define LINK_WDT_ERR_TRIG_EN to also request a reset after ERR_LIMIT consecutive rx_err cycles.
module link_watchdog #(
    parameter logic [19:0] TIMEOUT   = 20'h40000,
    parameter int          PULSE_LEN = 16,
    parameter logic [19:0] HOLDOFF   = 20'h30000,
    parameter logic [7:0]  ERR_LIMIT = 8'd64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rgmii_rstn,
    input  logic       mac_rst,
    input  logic       rx_heartbeat,
    input  logic       rx_err,
    output logic       rst_req_n,
    output logic       link_ok,
    output logic [7:0] req_count
);
    typedef enum logic [1:0] {WAIT = 2'b00, ARMED = 2'b01, REQ = 2'b10, HOLD = 2'b11} state_t;
    // Zero-length pulse or holdoff behaves as a single cycle.
    localparam logic [19:0] TO_LAST = TIMEOUT - 20'd1;
    localparam logic [19:0] PL_LAST = (PULSE_LEN > 1) ? 20'(PULSE_LEN - 1) : 20'd0;
    localparam logic [19:0] HO_LAST = (HOLDOFF > 20'd1) ? HOLDOFF - 20'd1 : 20'd0;
    state_t      state;
    logic [19:0] cnt;
    logic [2:0]  sync;
    logic        activity, abort, timeout, err_hit, trig;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) sync <= '0;
        else sync <= {sync[1:0], rx_heartbeat};

    assign activity = sync[1] ^ sync[2];
    assign abort    = mac_rst || !rgmii_rstn;
    assign timeout  = !activity && cnt == TO_LAST;
    assign trig     = timeout || err_hit;

`ifdef LINK_WDT_ERR_TRIG_EN
    logic [7:0] err_cnt;
    assign err_hit = rx_err && err_cnt + 8'd1 == ERR_LIMIT;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) err_cnt <= '0;
        else err_cnt <= (state == ARMED && !abort && !trig && rx_err) ? err_cnt + 8'd1 : '0;
`else
    logic err_unused;
    assign err_hit    = 1'b0;
    assign err_unused = rx_err;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= WAIT;
            cnt       <= '0;
            rst_req_n <= 1'b1;
            link_ok   <= 1'b0;
            req_count <= '0;
        end else begin
            case (state)
                WAIT: if (!abort) begin
                    state   <= ARMED;
                    link_ok <= 1'b1;
                end
                ARMED: if (abort) begin
                    state   <= WAIT;
                    link_ok <= 1'b0;
                    cnt     <= '0;
                end else if (trig) begin
                    state     <= REQ;
                    link_ok   <= 1'b0;
                    rst_req_n <= 1'b0;
                    cnt       <= '0;
                    req_count <= (req_count == 8'hff) ? req_count : req_count + 8'd1;
                end else begin
                    cnt <= activity ? '0 : cnt + 20'd1;
                end
                REQ: if (cnt == PL_LAST) begin
                    state     <= HOLD;
                    rst_req_n <= 1'b1;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 20'd1;
                end
                HOLD: if (cnt == HO_LAST) begin
                    state <= WAIT;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 20'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_link_watchdog.sv
// tb_link_watchdog: directed and randomized checks of link_watchdog against a timestamp-based model.
// The error-trigger expectations follow LINK_WDT_ERR_TRIG_EN when it is defined for the build.
module tb_link_watchdog;
    localparam int TO = 100, PL = 4, HO = 50, EL = 8;
    logic       clk = 1'b0, rstn = 1'b1, rgmii_rstn = 1'b1, mac_rst = 1'b1, rx_heartbeat = 1'b0, rx_err = 1'b0;
    logic       rst_req_n, link_ok;
    logic [7:0] req_count;
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    link_watchdog #(.TIMEOUT(20'd100), .PULSE_LEN(4), .HOLDOFF(20'd50), .ERR_LIMIT(8'd8)) dut (
        .clk(clk), .rstn(rstn), .rgmii_rstn(rgmii_rstn), .mac_rst(mac_rst),
        .rx_heartbeat(rx_heartbeat), .rx_err(rx_err),
        .rst_req_n(rst_req_n), .link_ok(link_ok), .req_count(req_count)
    );

    // Model: request windows are tracked as absolute edge numbers rather than counters.
    bit         m_armed, m_busy;
    int         m_n, m_ref, m_req, m_err, m_cnt;
    bit         hb_q[$];
    logic       exp_rst_req_n = 1'b1, exp_link_ok = 1'b0;
    logic [7:0] exp_req_count = 8'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_busy = 0; m_n = 0; m_ref = 0; m_req = 0; m_err = 0; m_cnt = 0;
        hb_q.delete();
        repeat (4) hb_q.push_back(1'b0);
        exp_rst_req_n = 1'b1; exp_link_ok = 1'b0; exp_req_count = 8'd0;
    endtask

    task automatic model_step();
        bit act, abort, err_trig;
        m_n++;
        hb_q.push_front(rx_heartbeat);
        act = hb_q[2] ^ hb_q[3];
        void'(hb_q.pop_back());
        abort = mac_rst || !rgmii_rstn;
        err_trig = 0;
        if (m_busy) begin
            if (m_n == m_req + PL + HO) m_busy = 0;
        end else if (!m_armed) begin
            if (!abort) begin m_armed = 1; m_ref = m_n; m_err = 0; end
        end else if (abort) begin
            m_armed = 0;
        end else begin
`ifdef LINK_WDT_ERR_TRIG_EN
            m_err = rx_err ? m_err + 1 : 0;
            err_trig = (m_err == EL);
`endif
            if (err_trig || (!act && m_n - m_ref == TO)) begin
                m_armed = 0; m_busy = 1; m_req = m_n;
                if (m_cnt < 255) m_cnt++;
            end else if (act) begin
                m_ref = m_n;
            end
        end
        exp_link_ok   = m_armed;
        exp_rst_req_n = !(m_busy && m_n < m_req + PL);
        exp_req_count = 8'(m_cnt);
    endtask

    initial forever begin
        @(posedge clk);
        if (rstn) model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("rst_req_n", {31'b0, rst_req_n}, {31'b0, exp_rst_req_n});
        chk("link_ok", {31'b0, link_ok}, {31'b0, exp_link_ok});
        chk("req_count", {24'b0, req_count}, {24'b0, exp_req_count});
    end

    initial begin
        #1500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        repeat (3) step();
        rstn = 1'b1;
    endtask

    // which: 0 = rst_req_n, 1 = link_ok; edges = negedges seen until match, -1 if the budget runs out.
    task automatic wait_for(input int which, input logic val, input int budget, output int edges);
        edges = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((which == 0 ? rst_req_n : link_ok) === val) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        int k;
        bit saw_low, burst;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("reset_rst_req_n", {31'b0, rst_req_n}, 32'd1);
        chk("reset_link_ok", {31'b0, link_ok}, 32'd0);
        chk("reset_req_count", {24'b0, req_count}, 32'd0);
        repeat (3) step();
        rstn = 1'b1;
        repeat (500) step();
        chk("mac_rst_hold_link_ok", {31'b0, link_ok}, 32'd0);
        chk("mac_rst_hold_rst_req_n", {31'b0, rst_req_n}, 32'd1);
        mac_rst = 1'b0;
        saw_low = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 50 == 0) rx_heartbeat = ~rx_heartbeat;
            step();
            if (!rst_req_n) saw_low = 1;
        end
        chk("heartbeat_link_ok", {31'b0, link_ok}, 32'd1);
        chk("heartbeat_no_request", {31'b0, saw_low}, 32'd0);
        chk("heartbeat_req_count", {24'b0, req_count}, 32'd0);
        rx_heartbeat = ~rx_heartbeat;
        wait_for(0, 1'b0, 400, k);
        chk("timeout_latency", k, 103);
        wait_for(0, 1'b1, 20, k);
        chk("pulse_width", k, 4);
        chk("timeout_req_count", {24'b0, req_count}, 32'd1);
        wait_for(1, 1'b1, 200, k);
        chk("rearm_delay", k, 51);
        #1;
        do_reset();
        wait_for(1, 1'b1, 20, k);
        chk("arm_after_reset", k, 1);
        #1;
        rx_err = 1'b1;
        repeat (8) step();
        rx_err = 1'b0;
        repeat (10) step();
`ifdef LINK_WDT_ERR_TRIG_EN
        chk("err8_req_count", {24'b0, req_count}, 32'd1);
`else
        chk("err8_req_count", {24'b0, req_count}, 32'd0);
`endif
        do_reset();
        wait_for(1, 1'b1, 20, k);
        #1;
        rx_err = 1'b1;
        repeat (7) step();
        rx_err = 1'b0;
        step();
        rx_err = 1'b1;
        repeat (7) step();
        rx_err = 1'b0;
        repeat (5) step();
        chk("err_7_1_7_req_count", {24'b0, req_count}, 32'd0);
        chk("err_7_1_7_link_ok", {31'b0, link_ok}, 32'd1);
        do_reset();
        wait_for(0, 1'b0, 300, k);
        chk("req_before_async_reset", {31'b0, rst_req_n}, 32'd0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("async_reset_rst_req_n", {31'b0, rst_req_n}, 32'd1);
        chk("async_reset_link_ok", {31'b0, link_ok}, 32'd0);
        chk("async_reset_req_count", {24'b0, req_count}, 32'd0);
        repeat (2) step();
        rstn = 1'b1;
        burst = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 89) == 0) rx_heartbeat = ~rx_heartbeat;
            mac_rst    = ($urandom_range(0, 149) == 0);
            rgmii_rstn = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 39) == 0) burst = ~burst;
            rx_err = burst && ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1499) == 0) begin
                rstn = 1'b0;
                model_reset();
                step();
                rstn = 1'b1;
            end
            step();
        end
        mac_rst = 1'b0;
        rgmii_rstn = 1'b1;
        rx_err = 1'b0;
        do_reset();
        repeat (260 * 155 + 300) step();
        chk("req_count_saturated", {24'b0, req_count}, 32'd255);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
